// File: rtl/xbus_model_pkg.sv
// Shared types, constants and helpers for the XBUS Wishbone slave responder model.
package xbus_model_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    typedef enum logic {
        RSP_ACK,
        RSP_ERR
    } rsp_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // 33-bit arithmetic so a window ending at the top of the address space does not wrap
    function automatic logic addr_in_window(input logic [31:0] adr,
                                            input logic [31:0] base,
                                            input int unsigned words);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, adr};
        lo = {1'b0, base};
        hi = lo + (33'(words) << 2);
        return (a >= lo) && (a < hi);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/xbus_mem_array.sv
// Word-addressed RAM with per-byte write enables, asynchronous clear and a
// combinational read port; the parent registers the read data.
module xbus_mem_array #(
    parameter int MEM_WORDS = 16,
    localparam int IDX_W = $clog2(MEM_WORDS)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdat_i,
    output logic [31:0]      rdat_o
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdat_i[8*b +: 8];
                end
            end
        end
    end

    assign rdat_o = mem_q[idx_i];

endmodule

// File: rtl/xbus_slave_model.sv
// Cycle-accurate Wishbone-b4 slave responder for the processor XBUS port: fixed
// latency, memory window, error injection, counters and a sticky protocol flag.
module xbus_slave_model
    import xbus_model_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          MEM_WORDS    = 16,
    parameter int          LATENCY      = 2,
    parameter bit          ERR_MISALIGN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [31:0]      xbus_adr_o,
    input  logic [31:0]      xbus_dat_o,
    input  logic [2:0]       xbus_tag_o,
    input  logic             xbus_we_o,
    input  logic [3:0]       xbus_sel_o,
    input  logic             xbus_stb_o,
    input  logic             xbus_cyc_o,
    output logic [31:0]      xbus_dat_i,
    output logic             xbus_ack_i,
    output logic             xbus_err_i,
    input  logic             inj_err_i,
    output logic [CNT_W-1:0] txn_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             proto_err_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W = $clog2(LATENCY + 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [31:0]      dat_q, dat_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic             proto_q, proto_d;

    // Captured request, held across the WAIT phase
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdat_q;
    logic             we_q;
    logic [3:0]       sel_q;
    rsp_e             rsp_q;

    logic             accept;
    logic             fire;
    logic             mem_we;
    logic [31:0]      mem_rdata;
    rsp_e             req_rsp;
    logic [IDX_W-1:0] f_idx;
    logic [31:0]      f_wdat;
    logic             f_we;
    logic [3:0]       f_sel;
    rsp_e             f_rsp;
    logic             unused_tag;

    assign unused_tag = ^xbus_tag_o;

    assign req_rsp = (!addr_in_window(xbus_adr_o, BASE_ADDR, MEM_WORDS)
                      || (ERR_MISALIGN && (xbus_adr_o[1:0] != 2'b00))
                      || inj_err_i) ? RSP_ERR : RSP_ACK;

    // In IDLE the live bus is the request (needed for single-cycle latency)
    assign f_idx  = (state_q == IDLE) ? xbus_adr_o[IDX_W+1:2] : idx_q;
    assign f_wdat = (state_q == IDLE) ? xbus_dat_o : wdat_q;
    assign f_we   = (state_q == IDLE) ? xbus_we_o  : we_q;
    assign f_sel  = (state_q == IDLE) ? xbus_sel_o : sel_q;
    assign f_rsp  = (state_q == IDLE) ? req_rsp    : rsp_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        dat_d   = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        txn_d   = txn_q;
        errc_d  = errc_q;
        proto_d = proto_q;
        accept  = 1'b0;
        fire    = 1'b0;
        mem_we  = 1'b0;

        if (xbus_stb_o && !xbus_cyc_o) begin
            proto_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (xbus_stb_o && xbus_cyc_o) begin
                    accept = 1'b1;
                    if (xbus_we_o && (xbus_sel_o == 4'b0000)) begin
                        proto_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        fire = 1'b1;
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (xbus_stb_o) begin
                    proto_d = 1'b1;
                end
                if (!xbus_cyc_o) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                    if (lat_q == LAT_W'(1)) begin
                        fire    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire) begin
            txn_d = sat_inc(txn_q);
            if (f_rsp == RSP_ERR) begin
                err_d  = 1'b1;
                errc_d = sat_inc(errc_q);
            end else begin
                ack_d  = 1'b1;
                mem_we = f_we;
                dat_d  = f_we ? 32'h0 : mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            lat_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            txn_q   <= '0;
            errc_q  <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
            errc_q  <= errc_d;
            proto_q <= proto_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_q  <= f_idx;
            wdat_q <= f_wdat;
            we_q   <= f_we;
            sel_q  <= f_sel;
            rsp_q  <= f_rsp;
        end
    end

    xbus_mem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .we_i  (mem_we),
        .be_i  (f_sel),
        .idx_i (f_idx),
        .wdat_i(f_wdat),
        .rdat_o(mem_rdata)
    );

    assign xbus_dat_i  = dat_q;
    assign xbus_ack_i  = ack_q;
    assign xbus_err_i  = err_q;
    assign txn_cnt_o   = txn_q;
    assign err_cnt_o   = errc_q;
    assign proto_err_o = proto_q;

endmodule

// File: tb/tb_xbus_slave_model.sv
// Self-checking bench for xbus_slave_model: table-driven transfers with a
// response scoreboard, plus abort, violation and reset sequences.
module tb_xbus_slave_model;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [2:0]  tag = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        inj = 1'b0;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic [15:0] txn_cnt;
    logic [15:0] err_cnt;
    logic        proto;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        inj;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    xbus_slave_model #(
        .BASE_ADDR   (32'h8000_0000),
        .MEM_WORDS   (16),
        .LATENCY     (LATENCY),
        .ERR_MISALIGN(1'b1)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .xbus_adr_o (adr),
        .xbus_dat_o (wdat),
        .xbus_tag_o (tag),
        .xbus_we_o  (we),
        .xbus_sel_o (sel),
        .xbus_stb_o (stb),
        .xbus_cyc_o (cyc),
        .xbus_dat_i (rdat),
        .xbus_ack_i (ack),
        .xbus_err_i (err),
        .inj_err_i  (inj),
        .txn_cnt_o  (txn_cnt),
        .err_cnt_o  (err_cnt),
        .proto_err_o(proto)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rstn) begin
            chk("ack_err_excl", 32'(ack & err), 32'h0);
            if (ack || err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got ack=%0b err=%0b dat=%h, expected none at %0t",
                             ack, err, rdat, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_err", 32'(err), 32'(e.err));
                    chk("rsp_dat", rdat, e.dat);
                end
            end else begin
                chk("idle_dat", rdat, 32'h0);
            end
        end
    end

    task automatic xfer(input vec_t v);
        int n;
        exp_t e;
        e.err = v.exp_err;
        e.dat = v.exp_dat;
        exp_q.push_back(e);
        @(posedge clk); #1;
        adr = v.adr; wdat = v.dat; we = v.we; sel = v.sel; inj = v.inj;
        stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; inj = 1'b0;
        n = 1;
        while (!(ack || err) && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(LATENCY));
        cyc = 1'b0; we = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic w,
                                input logic [3:0] s, input logic i, input logic ee,
                                input logic [31:0] ed);
        vec_t v;
        v.adr = a; v.dat = d; v.we = w; v.sel = s; v.inj = i; v.exp_err = ee; v.exp_dat = ed;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; inj = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_txn", 32'(txn_cnt), 32'h0);
        chk("rst_errcnt", 32'(err_cnt), 32'h0);
        chk("rst_proto", 32'(proto), 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
        tbl[1]  = mk(32'h8000_0004, 32'h0,         1'b0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF);
        tbl[2]  = mk(32'h8000_0008, 32'h1122_3344, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
        tbl[3]  = mk(32'h8000_0008, 32'hAABB_CCDD, 1'b1, 4'h5, 1'b0, 1'b0, 32'h0);
        tbl[4]  = mk(32'h8000_0008, 32'h0,         1'b0, 4'hF, 1'b0, 1'b0, 32'h11BB_33DD);
        tbl[5]  = mk(32'h9000_0000, 32'h0,         1'b0, 4'hF, 1'b0, 1'b1, 32'h0);
        tbl[6]  = mk(32'h8000_0002, 32'h0,         1'b0, 4'hF, 1'b0, 1'b1, 32'h0);
        tbl[7]  = mk(32'h8000_0000, 32'h0,         1'b0, 4'hF, 1'b1, 1'b1, 32'h0);
        tbl[8]  = mk(32'h8000_0040, 32'h5555_5555, 1'b1, 4'hF, 1'b0, 1'b1, 32'h0);
        tbl[9]  = mk(32'h8000_003C, 32'h0,         1'b0, 4'hF, 1'b0, 1'b0, 32'h0);
        tbl[10] = mk(32'h8000_003C, 32'h1234_5678, 1'b1, 4'h8, 1'b0, 1'b0, 32'h0);
        tbl[11] = mk(32'h8000_003C, 32'h0,         1'b0, 4'hF, 1'b0, 1'b0, 32'h1200_0000);
        tbl[12] = mk(32'h7FFF_FFFC, 32'h0,         1'b0, 4'hF, 1'b0, 1'b1, 32'h0);

        do_reset();

        foreach (tbl[i]) begin
            xfer(tbl[i]);
        end
        chk("tbl_txn", 32'(txn_cnt), 32'd13);
        chk("tbl_errcnt", 32'(err_cnt), 32'd5);
        chk("tbl_proto", 32'(proto), 32'h0);

        // Abort: cyc dropped in the cycle after the strobe
        @(posedge clk); #1;
        adr = 32'h8000_000C; wdat = 32'hFFFF_FFFF; we = 1'b1; sel = 4'hF;
        stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_txn", 32'(txn_cnt), 32'd13);
        xfer(mk(32'h8000_000C, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0));
        chk("abort_read_txn", 32'(txn_cnt), 32'd14);

        // Overlapping strobe while WAIT: flagged and ignored
        begin
            exp_t e;
            e.err = 1'b0; e.dat = 32'h0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        adr = 32'h8000_0014; wdat = 32'h0000_0055; we = 1'b1; sel = 4'hF;
        stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        adr = 32'h8000_0018; wdat = 32'h0000_0077;
        @(posedge clk); #1;
        chk("viol_ack", 32'(ack), 32'h1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("viol_proto", 32'(proto), 32'h1);
        xfer(mk(32'h8000_0018, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0));
        xfer(mk(32'h8000_0014, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_0055));
        chk("viol_proto_hold", 32'(proto), 32'h1);
        chk("viol_txn", 32'(txn_cnt), 32'd17);
        do_reset();
        #1;
        chk("post_rst_proto", 32'(proto), 32'h0);

        // Reset during WAIT: outputs clear at once, no late response, memory cleared
        xfer(mk(32'h8000_0010, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0));
        chk("mid_txn_before", 32'(txn_cnt), 32'd1);
        @(posedge clk); #1;
        adr = 32'h8000_0010; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_txn", 32'(txn_cnt), 32'h0);
        @(posedge clk); #1;
        cyc = 1'b0;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        xfer(mk(32'h8000_0010, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0));
        chk("mid_txn_after", 32'(txn_cnt), 32'd1);

        // Strobe without cyc
        chk("nocyc_proto_pre", 32'(proto), 32'h0);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b0;
        @(posedge clk); #1;
        stb = 1'b0;
        chk("nocyc_proto", 32'(proto), 32'h1);
        repeat (3) @(posedge clk);
        do_reset();

        // Write strobe with no byte lanes
        xfer(mk(32'h8000_0020, 32'h1111_1111, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0));
        chk("sel0_proto", 32'(proto), 32'h1);
        xfer(mk(32'h8000_0020, 32'h0, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xbus_slave_model.md
Name: xbus_slave_model

Overview:
- Cycle-accurate Wishbone-b4 slave responder for the neorv32 formal environment.
- Sits directly downstream of the processor XBUS master port.
- Consumes xbus_adr_o/dat_o/tag_o/we_o/sel_o/stb_o/cyc_o and produces xbus_dat_i/ack_i/err_i, which feed both the DUT and checker_top.
- Backs a small word-addressed memory window with configurable response latency and error injection.
- Keeps transaction/error counters and a sticky protocol-violation flag for checker assertions.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte base address of the memory window (MEM_WORDS*4 aligned).
- MEM_WORDS, 16, number of 32-bit words; power of two, at least 2.
- LATENCY, 2, cycles from the accepted stb to the ack/err pulse; at least 1.
- ERR_MISALIGN, 1, when 1 an access with adr[1:0]!=0 returns err.

Ports:
- clk_i  in  1  processor clock
- rstn_i  in  1  asynchronous active-low reset
- xbus_adr_o  in  32  request byte address
- xbus_dat_o  in  32  write data
- xbus_tag_o  in  3  access tag; unused by the model, available to checkers
- xbus_we_o  in  1  1=write, 0=read
- xbus_sel_o  in  4  byte-lane enables
- xbus_stb_o  in  1  single-cycle request strobe
- xbus_cyc_o  in  1  bus cycle active; held until ack/err
- xbus_dat_i  out  32  read data (valid with ack)
- xbus_ack_i  out  1  success response pulse
- xbus_err_i  out  1  error response pulse
- inj_err_i  in  1  force err on the request accepted this cycle
- txn_cnt_o  out  16  completed responses (ack or err)
- err_cnt_o  out  16  err responses
- proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rstn_i=0, asynchronous, active-low) forces the following:
  - xbus_dat_i=0, xbus_ack_i=0, xbus_err_i=0.
  - txn_cnt_o=0, err_cnt_o=0, proto_err_o=0.
  - State IDLE; all memory words = 0.
- State IDLE:
  - stb_o & cyc_o captures adr, dat, we, sel and the error decision, loads lat_cnt=LATENCY-1, then moves to WAIT.
  - If LATENCY=1, it moves straight to RESP behaviour: response in the next cycle.
- Error decision (captured at stb) is err if any of:
  - adr is outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS)
  - ERR_MISALIGN=1 and adr[1:0]!=0
  - inj_err_i=1 in the stb cycle
- State WAIT:
  - lat_cnt decrements each cycle.
  - At lat_cnt=0 the response is registered, so the pulse appears at stb cycle + LATENCY; the block then returns to IDLE.
- Response cycle, exactly one cycle wide, with ack and err mutually exclusive:
  - OK read: ack=1, dat_i=mem[index].
  - OK write: ack=1, dat_i=0; mem[index] bytes with sel=1 updated from captured dat_o.
  - Err: err=1, dat_i=0, no memory update.
- Memory index is adr[$clog2(MEM_WORDS)+1:2].
- Counters:
  - txn_cnt_o increments on every ack or err.
  - err_cnt_o increments on every err.
  - Both saturate at 16'hFFFF (no wrap).
- Abort: cyc_o=0 while in WAIT gives an immediate return to IDLE. No response, no write, no count.
- Protocol violations set proto_err_o until reset:
  - stb_o while in WAIT; the new request is ignored.
  - stb_o with cyc_o=0.
  - sel_o=0 on a write stb.
- Back-to-back: a new stb in the cycle right after the response pulse is accepted normally. A stb in the response cycle itself is a violation only if the state is still WAIT.
- dat_i returns to 0 the cycle after the pulse. Outputs are registered only, with no combinational path from inputs.

Decomposition:
- Package xbus_model_pkg holds:
  - state enum {IDLE, WAIT}
  - response enum {RSP_ACK, RSP_ERR}
  - CNT_W=16 and the saturation constant
  - function addr_in_window(adr, base, words)
- One sub-module: xbus_mem_array.
  - MEM_WORDS x 32 RAM with per-byte write enable and asynchronous reset to zero.
  - Read port is combinational on index; the registering happens in the parent.

Test Plan:
- Write then read: write adr=8000_0004, dat=DEADBEEF, sel=F; then read the same address. Expect ack 2 cycles after each stb and read dat_i=DEADBEEF; txn_cnt=2, err_cnt=0.
- Byte lanes: word 8000_0008 = 11223344; write dat=AABBCCDD, sel=0101, then read it. Expect dat_i=11BB33DD.
- Errors:
  - Read adr=9000_0000 gives err at +2 cycles, dat_i=0.
  - Read adr=8000_0002 gives err.
  - Read 8000_0000 with inj_err_i=1 gives err.
  - Result: err_cnt=3, ack never asserted.
- Abort: write stb to 8000_000C, drop cyc the next cycle. Expect no ack/err, memory unchanged (read returns 0), txn_cnt unchanged.
- Violation: second stb one cycle after the first (LATENCY=2). Expect proto_err_o=1 and exactly one ack; the flag holds until rstn_i pulse, after which all outputs and counters read 0.
- Reset mid-operation: assert rstn_i low during WAIT. Expect outputs 0 immediately (asynchronous), no response after release, and memory zeroed.
